// File: rtl/ddr3_avl_pkg.sv
//------------------------------------------------------------------------------
// ddr3_avl_pkg
// Shared types and constants for the DDR3 Avalon-MM responder.
//   state_t      : responder FSM states
//   AVL_SIZE_W   : width of the avl_size burst-length field
//   LFSR_SEED    : reset value of the stall LFSR
//   LFSR_TAPS    : feedback taps for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
//   lfsr_next()  : one step of the left-shifting stall LFSR
//------------------------------------------------------------------------------
package ddr3_avl_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WR_BURST = 2'd1,
      RD_BURST = 2'd2
   } state_t;

   localparam int AVL_SIZE_W = 3;

   localparam logic [AVL_SIZE_W-1:0] SIZE_ZERO = 3'd0;
   localparam logic [AVL_SIZE_W-1:0] SIZE_ONE  = 3'd1;

   localparam logic [7:0] LFSR_SEED = 8'hA5;
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   // Fibonacci form: the XOR of the tapped bits shifts in at bit 0.
   function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
      return {cur[6:0], ^(cur & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/ddr3_avl_responder_if.sv
//------------------------------------------------------------------------------
// ddr3_avl_responder_if
// Avalon-MM local port of the DDR3 controller (avl_* signals).
//   master modport : frame-buffer logic side (drives commands / write data)
//   slave  modport : responder side (drives ready and read data)
// Parameters: DATA_W beat width, ADDR_W beat address width.
//------------------------------------------------------------------------------
interface ddr3_avl_responder_if #(
   parameter int DATA_W = 128,
   parameter int ADDR_W = 26
);
   import ddr3_avl_pkg::*;

   logic                  avl_ready;
   logic                  avl_burstbegin;
   logic [AVL_SIZE_W-1:0] avl_size;
   logic                  avl_read_req;
   logic                  avl_write_req;
   logic [ADDR_W-1:0]     avl_addr;
   logic [DATA_W-1:0]     avl_wr_data;
   logic                  avl_read_data_valid;
   logic [DATA_W-1:0]     avl_read_data;

   modport master (
      input  avl_ready, avl_read_data_valid, avl_read_data,
      output avl_burstbegin, avl_size, avl_read_req, avl_write_req, avl_addr, avl_wr_data
   );

   modport slave (
      output avl_ready, avl_read_data_valid, avl_read_data,
      input  avl_burstbegin, avl_size, avl_read_req, avl_write_req, avl_addr, avl_wr_data
   );

endinterface

// File: rtl/ddr3_avl_lat_pipe.sv
//------------------------------------------------------------------------------
// ddr3_avl_lat_pipe
// Valid+data shift pipeline placed after the registered RAM output so the
// total read latency comes to RD_LATENCY. Data stages only load when the
// stage feeding them is valid, so the last stage holds its value while idle.
//   clk, reset          : clock, synchronous active-high reset
//   in_valid, in_data   : beat from the RAM output register
//   out_valid, out_data : beat delayed by DEPTH cycles
//------------------------------------------------------------------------------
module ddr3_avl_lat_pipe #(
   parameter int DATA_W = 128,
   parameter int DEPTH  = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data
);

   generate
      if (DEPTH == 0) begin : g_bypass
         assign out_valid = in_valid;
         assign out_data  = in_data;
      end else begin : g_pipe
         logic [DEPTH-1:0]             vld_r;
         logic [DEPTH-1:0][DATA_W-1:0] dat_r;

         // Shift valids every cycle; move data only behind a valid beat.
         always_ff @(posedge clk) begin
            if (reset) begin
               vld_r <= {DEPTH{1'b0}};
               dat_r <= {(DEPTH*DATA_W){1'b0}};
            end else begin
               vld_r[0] <= in_valid;
               if (in_valid) begin
                  dat_r[0] <= in_data;
               end
               for (int i = 1; i < DEPTH; i++) begin
                  vld_r[i] <= vld_r[i-1];
                  if (vld_r[i-1]) begin
                     dat_r[i] <= dat_r[i-1];
                  end
               end
            end
         end

         assign out_valid = vld_r[DEPTH-1];
         assign out_data  = dat_r[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/ddr3_avl_responder.sv
//------------------------------------------------------------------------------
// ddr3_avl_responder
// Avalon-MM responder standing in for the DDR3 controller local port.
// Bursts are backed by an on-chip single-port RAM; reads return after a
// fixed RD_LATENCY. An LFSR can randomly drop avl_ready to stress masters.
//   ddr3_clk  : single rising-edge clock
//   reset     : synchronous, active-high
//   avl       : slave end of the avl_* local port (see ddr3_avl_responder_if)
//   stall_en  : enables pseudo-random avl_ready deassertion
//   proto_err : sticky protocol-violation flag, cleared only by reset
//------------------------------------------------------------------------------
module ddr3_avl_responder #(
   parameter int DATA_W     = 128,
   parameter int ADDR_W     = 26,
   parameter int MEM_AW     = 12,
   parameter int RD_LATENCY = 4
) (
   input  logic                ddr3_clk,
   input  logic                reset,
   ddr3_avl_responder_if.slave avl,
   input  logic                stall_en,
   output logic                proto_err
);
   import ddr3_avl_pkg::*;

   state_t                state_r, state_next_s;
   logic [7:0]            lfsr_r;
   logic [MEM_AW-1:0]     base_r;
   logic [AVL_SIZE_W-1:0] len_r, beat_r, eff_size_s;
   logic                  proto_err_r, err_s;
   logic                  stall_s, ready_s, last_beat_s;
   logic                  cmd_acc_s, cmd_rd_s, mem_we_s, mem_re_s;
   logic [MEM_AW-1:0]     mem_addr_s;
   logic [DATA_W-1:0]     mem_r [0:(1<<MEM_AW)-1];
   logic                  ram_vld_r;
   logic [DATA_W-1:0]     ram_q_r;
   logic                  pipe_vld_s;
   logic [DATA_W-1:0]     pipe_dat_s;
   logic                  unused_addr_s;

   // Only the low MEM_AW address bits select a RAM word.
   assign unused_addr_s = ^avl.avl_addr[ADDR_W-1:MEM_AW];

   // Ready depends on registered state only, never on this cycle's inputs.
   assign stall_s     = stall_en & (lfsr_r[1:0] == 2'b00);
   assign ready_s     = (state_r != RD_BURST) & ~stall_s;
   assign eff_size_s  = (avl.avl_size == SIZE_ZERO) ? SIZE_ONE : avl.avl_size;
   assign last_beat_s = (beat_r == (len_r - SIZE_ONE));

   // FSM state register
   always_ff @(posedge ddr3_clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state decode
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (cmd_acc_s) begin
               if (cmd_rd_s) begin
                  state_next_s = RD_BURST;
               end else if (eff_size_s == SIZE_ONE) begin
                  state_next_s = IDLE;
               end else begin
                  state_next_s = WR_BURST;
               end
            end else begin
               state_next_s = IDLE;
            end
         end
         WR_BURST: begin
            if (mem_we_s && last_beat_s) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = WR_BURST;
            end
         end
         RD_BURST: begin
            if (last_beat_s) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = RD_BURST;
            end
         end
         default: state_next_s = IDLE;
      endcase
   end

   // FSM outputs: command accept, RAM strobes/address, protocol errors
   always_comb begin
      cmd_acc_s  = 1'b0;
      cmd_rd_s   = 1'b0;
      mem_we_s   = 1'b0;
      mem_re_s   = 1'b0;
      err_s      = 1'b0;
      mem_addr_s = base_r + MEM_AW'(beat_r);
      case (state_r)
         IDLE: begin
            if ((avl.avl_read_req | avl.avl_write_req) & ready_s) begin
               cmd_acc_s = 1'b1;
               cmd_rd_s  = avl.avl_read_req;
               err_s     = (avl.avl_size == SIZE_ZERO) | ~avl.avl_burstbegin |
                           (avl.avl_read_req & avl.avl_write_req);
               // Beat 0 of a write lands immediately at the command address.
               if (!avl.avl_read_req) begin
                  mem_we_s   = 1'b1;
                  mem_addr_s = avl.avl_addr[MEM_AW-1:0];
               end else begin
                  mem_we_s   = 1'b0;
               end
            end else begin
               cmd_acc_s = 1'b0;
            end
         end
         WR_BURST: begin
            mem_we_s = avl.avl_write_req & ready_s;
            err_s    = avl.avl_read_req | avl.avl_burstbegin;
         end
         RD_BURST: begin
            mem_re_s = 1'b1;
         end
         default: begin
            mem_re_s = 1'b0;
         end
      endcase
   end

   // Burst bookkeeping, stall LFSR and sticky error flag
   always_ff @(posedge ddr3_clk) begin
      if (reset) begin
         base_r      <= {MEM_AW{1'b0}};
         len_r       <= SIZE_ONE;
         beat_r      <= SIZE_ZERO;
         lfsr_r      <= LFSR_SEED;
         proto_err_r <= 1'b0;
      end else begin
         lfsr_r <= lfsr_next(lfsr_r);
         if (err_s) begin
            proto_err_r <= 1'b1;
         end
         if (cmd_acc_s) begin
            base_r <= avl.avl_addr[MEM_AW-1:0];
            len_r  <= eff_size_s;
            beat_r <= cmd_rd_s ? SIZE_ZERO : SIZE_ONE;
         end else if (mem_we_s | mem_re_s) begin
            beat_r <= beat_r + SIZE_ONE;
         end
      end
   end

   // RAM write port; contents survive reset
   always_ff @(posedge ddr3_clk) begin
      if (mem_we_s) begin
         mem_r[mem_addr_s] <= avl.avl_wr_data;
      end
   end

   // Registered RAM read output, first stage of the read latency
   always_ff @(posedge ddr3_clk) begin
      if (reset) begin
         ram_vld_r <= 1'b0;
         ram_q_r   <= {DATA_W{1'b0}};
      end else begin
         ram_vld_r <= mem_re_s;
         if (mem_re_s) begin
            ram_q_r <= mem_r[mem_addr_s];
         end
      end
   end

   ddr3_avl_lat_pipe #(
      .DATA_W (DATA_W),
      .DEPTH  (RD_LATENCY - 1)
   ) u_lat_pipe (
      .clk       (ddr3_clk),
      .reset     (reset),
      .in_valid  (ram_vld_r),
      .in_data   (ram_q_r),
      .out_valid (pipe_vld_s),
      .out_data  (pipe_dat_s)
   );

   assign avl.avl_ready           = ready_s;
   assign avl.avl_read_data_valid = pipe_vld_s;
   assign avl.avl_read_data       = pipe_dat_s;
   assign proto_err               = proto_err_r;

endmodule

// File: tb/tb_ddr3_avl_responder.sv
`timescale 1ns/1ps
module tb_ddr3_avl_responder;
   localparam int DATA_W = 128;
   localparam int ADDR_W = 26;
   localparam int MEM_AW = 12;
   localparam int RD_LAT = 4;

   logic ddr3_clk = 1'b0;
   logic reset    = 1'b1;
   logic stall_en = 1'b0;
   logic proto_err;

   ddr3_avl_responder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) avl ();

   ddr3_avl_responder #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_AW(MEM_AW), .RD_LATENCY(RD_LAT)
   ) dut (
      .ddr3_clk (ddr3_clk),
      .reset    (reset),
      .avl      (avl),
      .stall_en (stall_en),
      .proto_err(proto_err)
   );

   always #5 ddr3_clk = ~ddr3_clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Distinct, easily recognised beat data: pat(1) = {4{32'hC0DE0001}}
   function automatic logic [127:0] pat(input int i);
      logic [31:0] w;
      w = 32'hC0DE_0000 + 32'(i);
      return {w, w, w, w};
   endfunction

   function automatic int eff_len(input logic [2:0] s);
      return (s == 3'd0) ? 1 : int'(s);
   endfunction

   function automatic logic [11:0] wrap12(input logic [11:0] b, input int k);
      logic [11:0] kk;
      kk = 12'(k);
      return b + kk;
   endfunction

   // ---------------- reference model ----------------
   typedef struct { logic [127:0] data; int due; } exp_t;
   typedef struct { logic [127:0] data; int cyc; } log_t;
   exp_t         exp_q [$];
   log_t         rd_log [$];
   logic [127:0] shadow [0:4095];
   logic [7:0]   tb_lfsr;
   int           rd_left = 0;
   int           wr_left = 0;
   logic [11:0]  mdl_base, mdl_beat;
   int           cyc = 0;
   logic         mdl_live = 1'b0;
   int           vld_cnt = 0;
   int           total_exp = 0;
   logic         exp_ready;

   assign exp_ready = (rd_left == 0) && !(stall_en && (tb_lfsr[1:0] == 2'b00));

   always @(posedge ddr3_clk) begin
      cyc <= cyc + 1;
      if (reset) begin
         tb_lfsr  <= 8'hA5;
         rd_left  <= 0;
         wr_left  <= 0;
         mdl_live <= 1'b1;
         exp_q.delete();
      end else begin
         tb_lfsr <= {tb_lfsr[6:0], tb_lfsr[7] ^ tb_lfsr[5] ^ tb_lfsr[4] ^ tb_lfsr[3]};
         if (rd_left != 0) begin
            rd_left <= rd_left - 1;
         end else if (wr_left != 0) begin
            if (avl.avl_write_req && exp_ready) begin
               shadow[mdl_base + mdl_beat] <= avl.avl_wr_data;
               mdl_beat <= mdl_beat + 12'd1;
               wr_left  <= wr_left - 1;
            end
         end else if ((avl.avl_read_req || avl.avl_write_req) && exp_ready) begin
            if (avl.avl_read_req) begin
               rd_left   <= eff_len(avl.avl_size);
               total_exp <= total_exp + eff_len(avl.avl_size);
               for (int k = 0; k < eff_len(avl.avl_size); k++)
                  exp_q.push_back('{data: shadow[wrap12(avl.avl_addr[11:0], k)], due: cyc + 1 + k + RD_LAT});
            end else begin
               shadow[avl.avl_addr[11:0]] <= avl.avl_wr_data;
               mdl_base <= avl.avl_addr[11:0];
               mdl_beat <= 12'd1;
               wr_left  <= eff_len(avl.avl_size) - 1;
            end
         end
      end
   end

   // Per-cycle ready check and read-data scoreboard
   always @(negedge ddr3_clk) begin
      if (mdl_live) begin
         check_value("ready", avl.avl_ready, exp_ready);
         if (avl.avl_read_data_valid) begin
            vld_cnt <= vld_cnt + 1;
            rd_log.push_back('{data: avl.avl_read_data, cyc: cyc});
            if (exp_q.size() == 0) begin
               check_value("rd_unexpected", avl.avl_read_data_valid, 1'b0);
            end else begin
               check_value("rd_data", avl.avl_read_data, exp_q[0].data);
               check_value("rd_cycle", cyc, exp_q[0].due);
               void'(exp_q.pop_front());
            end
         end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
            check_value("rd_missing", avl.avl_read_data_valid, 1'b1);
            void'(exp_q.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge ddr3_clk);
      #1;
   endtask

   task automatic idle_bus();
      avl.avl_read_req   = 1'b0;
      avl.avl_write_req  = 1'b0;
      avl.avl_burstbegin = 1'b0;
   endtask

   task automatic issue(input logic rd, input logic wr, input logic bb, input logic [25:0] addr,
                        input logic [2:0] size, input logic [127:0] data);
      int guard = 0;
      avl.avl_read_req   = rd;
      avl.avl_write_req  = wr;
      avl.avl_burstbegin = bb;
      avl.avl_addr       = addr;
      avl.avl_size       = size;
      avl.avl_wr_data    = data;
      while (avl.avl_ready !== 1'b1 && guard < 64) begin
         step();
         guard++;
      end
      if (guard >= 64) check_value("ready_timeout", avl.avl_ready, 1'b1);
      step();
   endtask

   task automatic write_burst(input logic [25:0] addr, input logic [2:0] size, input int first, input logic bb);
      for (int i = 0; i < eff_len(size); i++)
         issue(1'b0, 1'b1, bb && (i == 0), addr, size, pat(first + i));
      idle_bus();
   endtask

   task automatic do_read(input logic [25:0] addr, input logic [2:0] size);
      issue(1'b1, 1'b0, 1'b1, addr, size, 128'd0);
      idle_bus();
   endtask

   task automatic drain();
      int guard = 0;
      while (exp_q.size() != 0 && guard < 200) begin
         step();
         guard++;
      end
      check_value("drain", exp_q.size(), 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic check_log(input string tag, input int first, input int n);
      check_value({tag, "_count"}, rd_log.size(), n);
      for (int i = 0; i < n && i < rd_log.size(); i++)
         check_value(tag, rd_log[i].data, pat(first + i));
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int t_acc;
      int snap;
      idle_bus();
      avl.avl_addr    = 26'd0;
      avl.avl_size    = 3'd0;
      avl.avl_wr_data = 128'd0;
      step();
      step();
      reset = 1'b0;

      check_value("rst_valid", avl.avl_read_data_valid, 1'b0);
      check_value("rst_data", avl.avl_read_data, 128'd0);
      check_value("rst_proto_err", proto_err, 1'b0);
      check_value("rst_ready", avl.avl_ready, 1'b1);

      // Test 1: write 4 beats at 0x10
      write_burst(26'h10, 3'd4, 0, 1'b1);
      check_value("t1_proto_err", proto_err, 1'b0);

      // Test 2: read 4 beats at 0x10, exact ready and data timing
      rd_log.delete();
      issue(1'b1, 1'b0, 1'b1, 26'h10, 3'd4, 128'd0);
      idle_bus();
      t_acc = cyc - 1;
      for (int k = 1; k <= 4; k++) begin
         check_value("t2_ready_low", avl.avl_ready, 1'b0);
         step();
      end
      check_value("t2_ready_high", avl.avl_ready, 1'b1);
      drain();
      check_log("t2_data", 0, 4);
      for (int k = 0; k < 4 && k < rd_log.size(); k++)
         check_value("t2_when", rd_log[k].cyc, t_acc + 5 + k);

      // Test 3: write across the top of the RAM and read back
      write_burst(26'hFFF, 3'd3, 4, 1'b1);
      rd_log.delete();
      do_read(26'hFFF, 3'd3);
      drain();
      check_log("t3_wrap", 4, 3);
      rd_log.delete();
      do_read(26'h000, 3'd2);
      drain();
      check_log("t3_low", 5, 2);

      // Test 5a: read and write together, read wins
      do_reset();
      write_burst(26'h20, 3'd2, 7, 1'b1);
      check_value("t5a_err_before", proto_err, 1'b0);
      rd_log.delete();
      issue(1'b1, 1'b1, 1'b1, 26'h20, 3'd2, pat(20));
      idle_bus();
      check_value("t5a_err", proto_err, 1'b1);
      drain();
      check_log("t5a_data", 7, 2);
      check_value("t5a_err_sticky", proto_err, 1'b1);

      // Test 5b: size 0 behaves as a single beat
      do_reset();
      check_value("t5b_err_cleared", proto_err, 1'b0);
      issue(1'b0, 1'b1, 1'b1, 26'h30, 3'd0, pat(9));
      idle_bus();
      check_value("t5b_err", proto_err, 1'b1);
      rd_log.delete();
      do_read(26'h30, 3'd1);
      drain();
      check_log("t5b_data", 9, 1);
      check_value("t5b_err_sticky", proto_err, 1'b1);

      // Test 5c: write without burstbegin still executes
      do_reset();
      check_value("t5c_err_cleared", proto_err, 1'b0);
      write_burst(26'h40, 3'd2, 10, 1'b0);
      check_value("t5c_err", proto_err, 1'b1);
      rd_log.delete();
      do_read(26'h40, 3'd2);
      drain();
      check_log("t5c_data", 10, 2);
      check_value("t5c_err_sticky", proto_err, 1'b1);

      // Test 4: random legal bursts with stalls
      do_reset();
      for (int j = 0; j < 16; j++)
         write_burst(26'h100 + 26'(4 * j), 3'd4, 100 + 4 * j, 1'b1);
      stall_en = 1'b1;
      for (int n = 0; n < 200; n++) begin
         logic [2:0]  sz;
         logic [25:0] a;
         sz = 3'($urandom_range(1, 7));
         a  = 26'h100 + 26'($urandom_range(0, 56));
         if ($urandom_range(0, 1) == 1) write_burst(a, sz, int'($urandom_range(0, 100000)), 1'b1);
         else do_read(a, sz);
      end
      drain();
      stall_en = 1'b0;
      repeat (3) step();
      check_value("t4_beat_count", vld_cnt, total_exp);
      check_value("t4_proto_err", proto_err, 1'b0);

      // Test 6: reset two cycles into a 7-beat read
      rd_log.delete();
      issue(1'b1, 1'b0, 1'b1, 26'h100, 3'd7, 128'd0);
      idle_bus();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_value("t6_ready_after_rst", avl.avl_ready, 1'b1);
      snap = vld_cnt;
      step();
      check_value("t6_ready_next", avl.avl_ready, 1'b1);
      repeat (15) step();
      check_value("t6_no_valid", vld_cnt, snap);
      rd_log.delete();
      do_read(26'h10, 3'd4);
      drain();
      check_log("t6_reread", 0, 4);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog cycles=%0d limit=50000", cyc);
      $fatal(1, "watchdog");
   end

endmodule
